clkhf_sequencer: RTL and testbench
==================================

// Module: clkhf_sequencer
// PURPOSE
//   Oscillator-side counterpart to the power management unit. Accepts a level
//   request for the high-frequency clock and drives the HF oscillator's
//   powerup/enable pins in a safe, timed order. Raises a four-phase ack only
//   once the clock is stable and gated through, and drops it only after full
//   shutdown. Runs on the always-on clock, between the power management unit
//   and the SB_HFOSC/clock gate.
// PARAMETERS
//   PU_CYCLES   16  cycles in PWRUP (powerup=1, enable=0) before enable
//   EN_CYCLES   4   cycles in STABLE (enable=1) before clock gated through
//   OFF_CYCLES  8   minimum cycles in PWRDN before a new request is honoured
//   All >=1. Timer width = $clog2(max(PU_CYCLES,EN_CYCLES,OFF_CYCLES)+1).
// PORTS
//   clk            in   1   always-on clock; single clock domain
//   rst_n          in   1   reset, synchronous, active-low
//   req            in   1   HF clock request from power management unit (level)
//   ack            out  1   four-phase ack: 1 = HF clock delivered/still owned
//   clkhf_powerup  out  1   to oscillator CLKHFPU
//   clkhf_enable   out  1   to oscillator CLKHFEN
//   clk_gate_en    out  1   enables HF clock gate toward the core
//   state_o        out  3   current state encoding (debug)
//   pu_count       out  16  completed power-ups, saturating
// BEHAVIOUR
//   - Reset: synchronous, active-low. Takes effect on the clk edge where rst_n=0
//     and wins over everything: state=OFF, timer=0, ack_r=0, pu_count=0,
//     all outputs 0.
//   - Outputs are registered; decoded from the state *after* each edge.
//     OFF=0, PWRUP=1, STABLE=2, ON=3, PWRDN=4. Encodings 5-7 -> OFF next edge.
//   - Output decode:
//       powerup = PWRUP|STABLE|ON
//       enable  = STABLE|ON
//       clk_gate_en = ON
//       ack = ack_r
//   - OFF: if req=1 -> PWRUP, timer=PU_CYCLES-1. One-edge latency from req seen.
//   - PWRUP: req=0 -> PWRDN, timer=OFF_CYCLES-1 (abort).
//     Else timer==0 -> STABLE, timer=EN_CYCLES-1. Else timer--.
//   - STABLE: req=0 -> PWRDN, timer=OFF_CYCLES-1 (abort).
//     Else timer==0 -> ON, ack_r<=1, pu_count++ (holds at 16'hFFFF).
//     Else timer--.
//   - ON: hold while req=1. req=0 -> PWRDN, timer=OFF_CYCLES-1.
//     gate_en, enable and powerup all fall on that same edge.
//   - PWRDN: req ignored. timer==0 -> OFF, ack_r<=0. Else timer--.
//     A re-request during PWRDN is serviced on the first edge in OFF.
//   - Aborts (from PWRUP/STABLE): ack_r never set; pu_count unchanged.
//     Still honour the full OFF_CYCLES minimum-off time.
//   - Handshake: ack rises exactly PU_CYCLES+EN_CYCLES edges after the edge
//     that samples req=1 in OFF. ack falls exactly OFF_CYCLES edges after the
//     edge that samples req=0 in ON. Requester must not drop req before ack=1
//     except to abort.
//   - Invariants:
//       enable=1 implies powerup=1
//       clk_gate_en=1 implies enable=1
//       clk_gate_en=1 implies ack=1
//     Assertions required in the bench.
// TESTING
//   1. rst_n=0 for 3 edges with req=1 -> all outputs 0, state_o=0,
//      pu_count=0; release -> PWRUP one edge later.
//   2. Defaults, req=1 sampled at edge N:
//        powerup=1 after N
//        enable=1 after N+16
//        clk_gate_en=ack=1 after N+20
//        pu_count=1
//   3. In ON, req=0 sampled at edge M:
//        gate_en/enable/powerup=0 after M
//        ack stays 1
//        ack=0 after M+8; state OFF
//   4. Abort, req=0 at PWRUP edge N+5:
//        powerup=0 next edge
//        ack stays 0 throughout
//        pu_count unchanged
//        OFF after 8 more edges
//   5. req re-asserted 2 edges into PWRDN -> no powerup until OFF reached;
//      PWRUP on the following edge.
//   6. rst_n=0 mid-ON -> all outputs 0 and pu_count=0 on that edge;
//      force pu_count to 16'hFFFF, complete a cycle -> stays 16'hFFFF.

Source files
------------

// File: rtl/clkhf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : clkhf_sequencer
//  Description : Oscillator-side power sequencer for the high-frequency clock.
//                Takes a level request from the power management unit, walks
//                the HF oscillator through powerup -> enable -> gated-through,
//                and answers with a four-phase ack. The ack rises only once
//                the clock is stable and gated to the core. It falls only
//                after a full shutdown and the minimum off time.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   always-on clock (single domain)
//    rst_n          in   1   synchronous active-low reset
//    req            in   1   HF clock request (level)
//    ack            out  1   four-phase ack, 1 = HF clock delivered/owned
//    clkhf_powerup  out  1   oscillator CLKHFPU
//    clkhf_enable   out  1   oscillator CLKHFEN
//    clk_gate_en    out  1   HF clock gate enable toward the core
//    state_o        out  3   current state (debug)
//    pu_count       out  16  completed power-ups, saturating at 16'hFFFF
// ============================================================================
module clkhf_sequencer #(
    parameter int PU_CYCLES  = 16,
    parameter int EN_CYCLES  = 4,
    parameter int OFF_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        ack,
    output logic        clkhf_powerup,
    output logic        clkhf_enable,
    output logic        clk_gate_en,
    output logic [2:0]  state_o,
    output logic [15:0] pu_count
);

    // ------------------------------------------------------------------
    // Timer sizing: wide enough to hold the largest reload value.
    // ------------------------------------------------------------------
    localparam int c_MAX_PE  = (PU_CYCLES > EN_CYCLES) ? PU_CYCLES : EN_CYCLES;
    localparam int c_MAX_ALL = (c_MAX_PE > OFF_CYCLES) ? c_MAX_PE : OFF_CYCLES;
    localparam int c_TMR_W   = $clog2(c_MAX_ALL + 1);

    localparam logic [c_TMR_W-1:0] c_PU_LOAD  = c_TMR_W'(PU_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_EN_LOAD  = c_TMR_W'(EN_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_OFF_LOAD = c_TMR_W'(OFF_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------
    // State encoding (visible on state_o, so values are fixed).
    // ------------------------------------------------------------------
    localparam logic [2:0] c_S_OFF    = 3'd0;
    localparam logic [2:0] c_S_PWRUP  = 3'd1;
    localparam logic [2:0] c_S_STABLE = 3'd2;
    localparam logic [2:0] c_S_ON     = 3'd3;
    localparam logic [2:0] c_S_PWRDN  = 3'd4;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_ack;
    logic [15:0]        r_pu_count;
    logic               r_powerup;
    logic               r_enable;
    logic               r_gate_en;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [2:0]         w_state_nxt;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic               w_ack_nxt;
    logic [15:0]        w_pu_count_nxt;
    logic               w_timer_zero;

    assign w_timer_zero = (r_timer == '0);

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_ack_nxt      = r_ack;
        w_pu_count_nxt = r_pu_count;

        case (r_state)
            c_S_OFF: begin
                if (req) begin
                    w_state_nxt = c_S_PWRUP;
                    w_timer_nxt = c_PU_LOAD;
                end
            end

            c_S_PWRUP: begin
                // Dropping req before ack is an abort; the oscillator still
                // gets its full minimum off time before it may restart.
                if (!req) begin
                    w_state_nxt = c_S_PWRDN;
                    w_timer_nxt = c_OFF_LOAD;
                end else if (w_timer_zero) begin
                    w_state_nxt = c_S_STABLE;
                    w_timer_nxt = c_EN_LOAD;
                end else begin
                    w_timer_nxt = r_timer - c_TMR_ONE;
                end
            end

            c_S_STABLE: begin
                if (!req) begin
                    w_state_nxt = c_S_PWRDN;
                    w_timer_nxt = c_OFF_LOAD;
                end else if (w_timer_zero) begin
                    w_state_nxt = c_S_ON;
                    w_ack_nxt   = 1'b1;
                    if (r_pu_count != c_CNT_MAX) begin
                        w_pu_count_nxt = r_pu_count + 16'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer - c_TMR_ONE;
                end
            end

            c_S_ON: begin
                if (!req) begin
                    w_state_nxt = c_S_PWRDN;
                    w_timer_nxt = c_OFF_LOAD;
                end
            end

            c_S_PWRDN: begin
                // req is deliberately ignored here; a re-request is picked
                // up by the OFF state on the edge after the timer expires.
                if (w_timer_zero) begin
                    w_state_nxt = c_S_OFF;
                    w_ack_nxt   = 1'b0;
                end else begin
                    w_timer_nxt = r_timer - c_TMR_ONE;
                end
            end

            default: begin
                // Unused encodings recover to OFF on the next edge.
                w_state_nxt = c_S_OFF;
                w_timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered output decode. Outputs are decoded from the
    // next state so they line up with state_o after every edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_S_OFF;
            r_timer    <= '0;
            r_ack      <= 1'b0;
            r_pu_count <= 16'd0;
            r_powerup  <= 1'b0;
            r_enable   <= 1'b0;
            r_gate_en  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_ack      <= w_ack_nxt;
            r_pu_count <= w_pu_count_nxt;
            r_powerup  <= (w_state_nxt == c_S_PWRUP) ||
                          (w_state_nxt == c_S_STABLE) ||
                          (w_state_nxt == c_S_ON);
            r_enable   <= (w_state_nxt == c_S_STABLE) ||
                          (w_state_nxt == c_S_ON);
            r_gate_en  <= (w_state_nxt == c_S_ON);
        end
    end

    assign ack           = r_ack;
    assign clkhf_powerup = r_powerup;
    assign clkhf_enable  = r_enable;
    assign clk_gate_en   = r_gate_en;
    assign state_o       = r_state;
    assign pu_count      = r_pu_count;

endmodule
`default_nettype wire

// File: tb/tb_clkhf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clkhf_sequencer
//  Description : Self-checking bench for clkhf_sequencer. A phase/elapsed-time
//                model predicts every output each cycle; directed sequences pin
//                the handshake timing with literal values, then random req and
//                reset traffic is compared cycle by cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clkhf_sequencer;

    localparam int PU   = 16;
    localparam int EN   = 4;
    localparam int OFFC = 8;

    // Phase numbering matches the published debug encoding.
    localparam int P_OFF = 0, P_PWRUP = 1, P_STABLE = 2, P_ON = 3, P_PWRDN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        ack;
    logic        clkhf_powerup;
    logic        clkhf_enable;
    logic        clk_gate_en;
    logic [2:0]  state_o;
    logic [15:0] pu_count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    clkhf_sequencer #(
        .PU_CYCLES (PU),
        .EN_CYCLES (EN),
        .OFF_CYCLES(OFFC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .ack          (ack),
        .clkhf_powerup(clkhf_powerup),
        .clkhf_enable (clkhf_enable),
        .clk_gate_en  (clk_gate_en),
        .state_o      (state_o),
        .pu_count     (pu_count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: current phase, edges spent in it, ack, count.
    // Each timed phase lasts a fixed number of edges, then moves on.
    // ------------------------------------------------------------------
    int          m_ph  = P_OFF;
    int          m_el  = 0;
    bit          m_ack = 1'b0;
    int unsigned m_cnt = 0;

    task automatic enter(input int ph);
        m_ph = ph;
        m_el = 0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            enter(P_OFF);
            m_ack = 1'b0;
            m_cnt = 0;
        end else begin
            case (m_ph)
                P_OFF:    if (req) enter(P_PWRUP);
                P_PWRUP: begin
                    if (!req)                enter(P_PWRDN);
                    else if (m_el == PU - 1) enter(P_STABLE);
                    else                     m_el++;
                end
                P_STABLE: begin
                    if (!req) enter(P_PWRDN);
                    else if (m_el == EN - 1) begin
                        enter(P_ON);
                        m_ack = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                    end else m_el++;
                end
                P_ON:     if (!req) enter(P_PWRDN);
                P_PWRDN: begin
                    if (m_el == OFFC - 1) begin
                        enter(P_OFF);
                        m_ack = 1'b0;
                    end else m_el++;
                end
                default:  enter(P_OFF);
            endcase
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare against the model, plus the output invariants.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("state",   int'(state_o),       m_ph);
            check("powerup", int'(clkhf_powerup), int'(m_ph == P_PWRUP || m_ph == P_STABLE || m_ph == P_ON));
            check("enable",  int'(clkhf_enable),  int'(m_ph == P_STABLE || m_ph == P_ON));
            check("gate_en", int'(clk_gate_en),   int'(m_ph == P_ON));
            check("ack",     int'(ack),           int'(m_ack));
            check("pu_count", int'(pu_count),     int'(m_cnt));
            check("inv_en_pu",   int'(clkhf_enable && !clkhf_powerup), 0);
            check("inv_gate_en", int'(clk_gate_en && !clkhf_enable),   0);
            check("inv_gate_ack", int'(clk_gate_en && !ack),           0);
        end
    end

    a_en_pu: assert property (@(posedge clk) clkhf_enable |-> clkhf_powerup)
        else $error("[TB] FAIL assert enable without powerup");
    a_gate_en: assert property (@(posedge clk) clk_gate_en |-> clkhf_enable)
        else $error("[TB] FAIL assert gate without enable");
    a_gate_ack: assert property (@(posedge clk) clk_gate_en |-> ack)
        else $error("[TB] FAIL assert gate without ack");

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Stimulus with literal expectations pinning the timing.
    // ------------------------------------------------------------------
    initial begin
        // Reset held for three edges with req asserted.
        rst_n = 1'b0;
        req   = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        ticks(2);
        check("rst_state", int'(state_o), 0);
        check("rst_powerup", int'(clkhf_powerup), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_count", int'(pu_count), 0);

        // Release: req=1 sampled at edge N, PWRUP right after it.
        rst_n = 1'b1;
        ticks(1);
        check("up_state_N", int'(state_o), 1);
        check("up_powerup_N", int'(clkhf_powerup), 1);
        ticks(15);
        check("up_enable_N15", int'(clkhf_enable), 0);
        ticks(1);
        check("up_enable_N16", int'(clkhf_enable), 1);
        check("up_state_N16", int'(state_o), 2);
        ticks(3);
        check("up_ack_N19", int'(ack), 0);
        ticks(1);
        check("up_ack_N20", int'(ack), 1);
        check("up_gate_N20", int'(clk_gate_en), 1);
        check("up_count", int'(pu_count), 1);

        // Release from ON: everything but ack drops at M, ack at M+8.
        ticks(3);
        req = 1'b0;
        ticks(1);
        check("dn_powerup_M", int'(clkhf_powerup), 0);
        check("dn_gate_M", int'(clk_gate_en), 0);
        check("dn_ack_M", int'(ack), 1);
        ticks(7);
        check("dn_ack_M7", int'(ack), 1);
        ticks(1);
        check("dn_ack_M8", int'(ack), 0);
        check("dn_state_M8", int'(state_o), 0);

        // Abort during PWRUP at edge N+5.
        req = 1'b1;
        ticks(5);
        req = 1'b0;
        ticks(1);
        check("ab_powerup", int'(clkhf_powerup), 0);
        check("ab_state", int'(state_o), 4);
        check("ab_count", int'(pu_count), 1);
        ticks(7);
        check("ab_state_7", int'(state_o), 4);
        ticks(1);
        check("ab_state_off", int'(state_o), 0);

        // Full power-up, then re-request two edges into PWRDN.
        req = 1'b1;
        ticks(21);
        check("rr_state_on", int'(state_o), 3);
        req = 1'b0;
        ticks(2);
        req = 1'b1;
        ticks(6);
        check("rr_powerup_M7", int'(clkhf_powerup), 0);
        ticks(1);
        check("rr_state_M8", int'(state_o), 0);
        check("rr_powerup_M8", int'(clkhf_powerup), 0);
        ticks(1);
        check("rr_state_M9", int'(state_o), 1);
        ticks(20);
        check("rr_count", int'(pu_count), 3);
        check("rr_ack", int'(ack), 1);

        // Reset while ON.
        rst_n = 1'b0;
        ticks(1);
        check("mr_ack", int'(ack), 0);
        check("mr_gate", int'(clk_gate_en), 0);
        check("mr_count", int'(pu_count), 0);
        rst_n = 1'b1;
        req   = 1'b0;
        ticks(2);

        // Unused encoding recovers to OFF.
        #1;
        force dut.r_state = 3'd5;
        m_ph = 5;
        #1;
        release dut.r_state;
        ticks(1);
        check("bad_enc_off", int'(state_o), 0);

        // Saturation of the power-up counter.
        #1;
        force dut.r_pu_count = 16'hFFFE;
        m_cnt = 32'hFFFE;
        #1;
        release dut.r_pu_count;
        ticks(1);
        req = 1'b1;
        ticks(21);
        check("sat_first", int'(pu_count), 65535);
        req = 1'b0;
        ticks(9);
        req = 1'b1;
        ticks(21);
        check("sat_hold", int'(pu_count), 65535);
        req = 1'b0;
        ticks(9);

        // Random req / reset traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) req = ~req;
            rst_n = ($urandom_range(0, 299) != 0);
            ticks(1);
        end

        rst_n = 1'b1;
        req   = 1'b0;
        ticks(12);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
